// File: rtl/t_port_capture.sv
// Capture FIFO for the CPU T output port: strobed (optionally change-only) samples are
// buffered and drained over a valid/ready interface with a registered fall-through head.
module t_port_capture #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = 8,
    parameter bit          CHANGE_ONLY = 1'b0
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [WIDTH-1:0]       T_In,
    input  logic                   T_Strobe,
    output logic [WIDTH-1:0]       Out_Data,
    output logic                   Out_Valid,
    input  logic                   Out_Ready,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Full,
    output logic                   Overflow,
    output logic [7:0]             Drop_Count,
    input  logic                   Clear_Overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] last_q;
    logic             have_last_q;
    logic             valid_q;
    logic             full_q;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_q, drop_d;

    logic push_req;
    logic pop;
    logic wr_en;
    logic drop;

    always_comb begin
        push_req = T_Strobe && (!CHANGE_ONLY || !have_last_q || (T_In != last_q));
        pop      = valid_q && Out_Ready;
        // A pop in the same cycle frees the slot, so a push while full still lands.
        wr_en    = push_req && (!full_q || pop);
        drop     = push_req && full_q && !pop;

        wptr_d  = wr_en ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = pop   ? rptr_q + PtrW'(1) : rptr_q;
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - CntW'(1);
        end

        // The new head may be the byte written this very cycle, which is not in mem yet.
        data_d = data_q;
        if (count_d != '0) begin
            data_d = (wr_en && (wptr_q == rptr_d)) ? T_In : mem[rptr_d];
        end

        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (Clear_Overflow) begin
                drop_d = 8'd1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (Clear_Overflow) begin
            overflow_d = 1'b0;
            drop_d     = 8'd0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset && wr_en) begin
            mem[wptr_q] <= T_In;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            data_q      <= '0;
            last_q      <= '0;
            have_last_q <= 1'b0;
            valid_q     <= 1'b0;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            drop_q      <= 8'd0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            valid_q    <= (count_d != '0);
            full_q     <= (count_d == CntW'(DEPTH));
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            if (wr_en) begin
                last_q      <= T_In;
                have_last_q <= 1'b1;
            end
        end
    end

    assign Out_Data   = data_q;
    assign Out_Valid  = valid_q;
    assign Count      = count_q;
    assign Full       = full_q;
    assign Overflow   = overflow_q;
    assign Drop_Count = drop_q;

endmodule

// File: tb/tb_t_port_capture.sv
// Bench for t_port_capture: a plain-queue reference model for both capture modes, checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_t_port_capture;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       strobe;
    logic       ready;
    logic       clr;
    logic [7:0] tin;

    logic [7:0] o_data  [2];
    logic       o_valid [2];
    logic [3:0] o_cnt   [2];
    logic       o_full  [2];
    logic       o_ovf   [2];
    logic [7:0] o_dcnt  [2];

    always #5 clk = ~clk;

    t_port_capture #(.WIDTH(8), .DEPTH(DEPTH), .CHANGE_ONLY(1'b0)) u_dut_all (
        .Clock(clk), .Reset(rst), .T_In(tin), .T_Strobe(strobe),
        .Out_Data(o_data[0]), .Out_Valid(o_valid[0]), .Out_Ready(ready),
        .Count(o_cnt[0]), .Full(o_full[0]), .Overflow(o_ovf[0]),
        .Drop_Count(o_dcnt[0]), .Clear_Overflow(clr)
    );

    t_port_capture #(.WIDTH(8), .DEPTH(DEPTH), .CHANGE_ONLY(1'b1)) u_dut_chg (
        .Clock(clk), .Reset(rst), .T_In(tin), .T_Strobe(strobe),
        .Out_Data(o_data[1]), .Out_Valid(o_valid[1]), .Out_Ready(ready),
        .Count(o_cnt[1]), .Full(o_full[1]), .Overflow(o_ovf[1]),
        .Drop_Count(o_dcnt[1]), .Clear_Overflow(clr)
    );

    // Reference model: index 0 captures every strobe, index 1 only on change.
    logic [7:0] mq [2][$];
    int         m_ovf  [2];
    int         m_dcnt [2];
    int         m_have [2];
    logic [7:0] m_last [2];
    logic [7:0] m_data [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                mq[m].delete();
                m_ovf[m]  = 0;
                m_dcnt[m] = 0;
                m_have[m] = 0;
                m_last[m] = 8'h00;
                m_data[m] = 8'h00;
            end else begin
                bit req;
                bit dropped;
                dropped = 1'b0;
                req = strobe && ((m == 0) || (m_have[m] == 0) || (tin != m_last[m]));
                if (ready && mq[m].size() > 0) void'(mq[m].pop_front());
                if (req) begin
                    if (mq[m].size() < DEPTH) begin
                        mq[m].push_back(tin);
                        m_last[m] = tin;
                        m_have[m] = 1;
                    end else begin
                        dropped   = 1'b1;
                        m_ovf[m]  = 1;
                        m_dcnt[m] = clr ? 1 : ((m_dcnt[m] < 255) ? m_dcnt[m] + 1 : 255);
                    end
                end
                if (!dropped && clr) begin
                    m_ovf[m]  = 0;
                    m_dcnt[m] = 0;
                end
                if (mq[m].size() > 0) m_data[m] = mq[m][0];
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (started) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("m%0d count", m), o_cnt[m], mq[m].size());
                chk($sformatf("m%0d valid", m), o_valid[m], mq[m].size() > 0);
                chk($sformatf("m%0d full", m), o_full[m], mq[m].size() == DEPTH);
                chk($sformatf("m%0d overflow", m), o_ovf[m], m_ovf[m]);
                chk($sformatf("m%0d drop_count", m), o_dcnt[m], m_dcnt[m]);
                chk($sformatf("m%0d data", m), o_data[m], m_data[m]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            strobe = 1'b1;
            tin    = 8'(first + i);
            cyc();
        end
        strobe = 1'b0;
    endtask

    task automatic drain(input int n);
        ready = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        ready = 1'b0;
    endtask

    task automatic clear_pulse();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        strobe = 1'b1;
        tin    = 8'h55;
        ready  = 1'b0;
        clr    = 1'b0;
        cyc();
        cyc();
        started = 1'b1;
        chk("rst count", o_cnt[0], 0);
        chk("rst valid", o_valid[0], 0);
        chk("rst overflow", o_ovf[0], 0);
        chk("rst drop_count", o_dcnt[0], 0);

        rst = 1'b0;
        cyc();
        strobe = 1'b0;
        chk("post-rst count", o_cnt[0], 1);
        chk("post-rst data", o_data[0], 8'h55);
        chk("post-rst count chg", o_cnt[1], 1);
        drain(1);

        // Ordering
        strobe = 1'b1; tin = 8'd3; cyc();
        tin = 8'd7; cyc();
        tin = 8'd9; cyc();
        strobe = 1'b0;
        chk("order count", o_cnt[0], 3);
        chk("order head", o_data[0], 3);
        ready = 1'b1;
        cyc(); chk("order second", o_data[0], 7);
        cyc(); chk("order third", o_data[0], 9);
        cyc(); chk("order valid end", o_valid[0], 0);
        chk("order count end", o_cnt[0], 0);
        ready = 1'b0;

        // Overflow
        push_seq(1, 10);
        chk("ovf count", o_cnt[0], 8);
        chk("ovf full", o_full[0], 1);
        chk("ovf flag", o_ovf[0], 1);
        chk("ovf drops", o_dcnt[0], 2);
        ready = 1'b1;
        for (int v = 1; v <= 8; v++) begin
            chk("ovf drain", o_data[0], v);
            cyc();
        end
        ready = 1'b0;
        clear_pulse();
        chk("clr flag", o_ovf[0], 0);
        chk("clr drops", o_dcnt[0], 0);

        // Full with simultaneous push and pop
        push_seq(1, 8);
        strobe = 1'b1; tin = 8'hAA; ready = 1'b1;
        cyc();
        strobe = 1'b0; ready = 1'b0;
        chk("fullpp count", o_cnt[0], 8);
        chk("fullpp ovf", o_ovf[0], 0);
        ready = 1'b1;
        for (int v = 2; v <= 9; v++) begin
            chk("fullpp drain", o_data[0], (v == 9) ? 8'hAA : v);
            cyc();
        end
        ready = 1'b0;
        chk("fullpp empty", o_valid[0], 0);

        // Clear colliding with a drop
        push_seq(1, 8);
        push_seq(20, 4);
        chk("coll drops before", o_dcnt[0], 4);
        clr = 1'b1; strobe = 1'b1; tin = 8'd30;
        cyc();
        clr = 1'b0; strobe = 1'b0;
        chk("coll ovf", o_ovf[0], 1);
        chk("coll drops", o_dcnt[0], 1);
        drain(8);
        clear_pulse();

        // Drop counter saturation
        push_seq(1, 8);
        strobe = 1'b1; tin = 8'd100;
        for (int i = 0; i < 260; i++) cyc();
        strobe = 1'b0;
        chk("sat drops", o_dcnt[0], 255);
        chk("sat drops chg", o_dcnt[1], 255);
        clear_pulse();
        drain(8);

        // Change-only qualification
        strobe = 1'b1;
        tin = 8'd5; cyc(); cyc(); cyc();
        tin = 8'd6; cyc(); cyc();
        tin = 8'd5; cyc();
        strobe = 1'b0;
        chk("chg count", o_cnt[1], 3);
        chk("chg all count", o_cnt[0], 6);
        chk("chg head", o_data[1], 5);
        ready = 1'b1;
        cyc(); chk("chg second", o_data[1], 6);
        cyc(); chk("chg third", o_data[1], 5);
        drain(4);
        rst = 1'b1; cyc(); rst = 1'b0;
        strobe = 1'b1; tin = 8'd0; cyc(); strobe = 1'b0;
        chk("chg first after rst", o_cnt[1], 1);
        drain(1);

        // Randomized traffic; ready bias alternates so the FIFO both fills and empties.
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 199) == 0);
            strobe = ($urandom_range(0, 2) != 0);
            tin    = strobe ? 8'($urandom_range(0, 3)) : 'x;
            ready  = ((i / 150) % 2 == 0) ? ($urandom_range(0, 4) == 0)
                                          : ($urandom_range(0, 4) != 0);
            clr    = ($urandom_range(0, 29) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
